// File: rtl/dma_cpucr_if.sv
// dma_cpucr_if -- command and bus-arbitration signals of the CPUCR block-copy DMA.
//   start/src_addr/dst_addr/len : copy request from the controlling agent
//   busy/done                   : copy status back to the agent
//   SDMA (active-low) / BD      : bus request to the CPUCR arbiter / its grant
// Modport slave is the DMA side, modport master is the requesting/arbitrating side.
interface dma_cpucr_if;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [7:0]  len;
  logic        busy;
  logic        done;
  logic        SDMA;
  logic        BD;

  modport slave (
    input  start, src_addr, dst_addr, len, BD,
    output busy, done, SDMA
  );

  modport master (
    output start, src_addr, dst_addr, len, BD,
    input  busy, done, SDMA
  );
endinterface

// File: rtl/dma_cpucr.sv
// dma_cpucr -- byte-wise block copy engine that borrows the CPUCR memory bus.
// Each byte costs READ, WRITE, NEXT; after BURST bytes the bus is handed back
// for one cycle (REL) before it is requested again.
// Ports:
//   clk        system clock, rising edge
//   RPS        asynchronous active-high reset
//   ctl        dma_cpucr_if.slave: start/src_addr/dst_addr/len in, busy/done out,
//              SDMA (active-low request) out, BD (grant) in
//   Direccion  memory address, tri-stated unless the bus is owned and granted
//   LE         1 = read, 0 = write, tri-stated like Direccion
//   Datos      bidirectional data, driven only during a granted WRITE
// The tri-state bus stays as plain ports so it resolves against the memory
// drivers directly at the net level.
module dma_cpucr #(
  parameter int BURST = 4
) (
  input  logic        clk,
  input  logic        RPS,
  dma_cpucr_if.slave  ctl,
  output logic [15:0] Direccion,
  output logic        LE,
  inout  wire  [7:0]  Datos
);

  localparam int BW = $clog2(BURST + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    READ,
    WRITE,
    NEXT,
    REL,
    DONE
  } state_t;

  state_t         state_reg;
  logic [15:0]    sp_reg;
  logic [15:0]    dp_reg;
  logic [7:0]     cnt_reg;
  logic [BW-1:0]  burst_reg;
  logic [7:0]     buf_reg;
  logic           sdma_reg;
  logic           busy_reg;
  logic           done_reg;

  // The bus is driven only while the grant is actually present, so a grant
  // withdrawn mid-byte releases the lines in that very cycle.
  logic        rd_en;
  logic        wr_en;
  logic        bus_en;
  logic [15:0] addr_mux;

  assign rd_en    = (state_reg == READ)  && ctl.BD;
  assign wr_en    = (state_reg == WRITE) && ctl.BD;
  assign bus_en   = rd_en || wr_en;
  assign addr_mux = rd_en ? sp_reg : dp_reg;

  assign Direccion = bus_en ? addr_mux : 16'hzzzz;
  assign LE        = bus_en ? rd_en : 1'bz;
  assign Datos     = wr_en ? buf_reg : 8'hzz;

  assign ctl.SDMA = sdma_reg;
  assign ctl.busy = busy_reg;
  assign ctl.done = done_reg;

  // Status outputs are registered together with the state they belong to:
  // every transition sets sdma/busy/done for the state being entered.
  always_ff @(posedge clk or posedge RPS) begin
    if (RPS) begin
      state_reg <= IDLE;
      sp_reg    <= 16'd0;
      dp_reg    <= 16'd0;
      cnt_reg   <= 8'd0;
      burst_reg <= '0;
      buf_reg   <= 8'd0;
      sdma_reg  <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ctl.start) begin
            sp_reg  <= ctl.src_addr;
            dp_reg  <= ctl.dst_addr;
            cnt_reg <= ctl.len;
            if (ctl.len == 8'd0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= REQ;
              sdma_reg  <= 1'b0;
              busy_reg  <= 1'b1;
            end
          end
        end

        REQ: begin
          if (ctl.BD) begin
            state_reg <= READ;
            burst_reg <= '0;
          end
        end

        READ: begin
          // Grant lost: abandon this byte without touching pointers and retry.
          if (ctl.BD) begin
            buf_reg   <= Datos;
            state_reg <= WRITE;
          end else begin
            state_reg <= REQ;
          end
        end

        WRITE: begin
          if (ctl.BD) begin
            state_reg <= NEXT;
          end else begin
            state_reg <= REQ;
          end
        end

        NEXT: begin
          sp_reg    <= sp_reg + 16'd1;
          dp_reg    <= dp_reg + 16'd1;
          cnt_reg   <= cnt_reg - 8'd1;
          burst_reg <= burst_reg + 1'b1;
          if (cnt_reg == 8'd1) begin
            // Last byte: hand the bus back via REL if still granted,
            // otherwise the grant is already gone and we finish directly.
            sdma_reg <= 1'b1;
            if (ctl.BD) begin
              state_reg <= REL;
            end else begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end else if (!ctl.BD) begin
            state_reg <= REQ;
          end else if (burst_reg == BW'(BURST - 1)) begin
            state_reg <= REL;
            sdma_reg  <= 1'b1;
          end else begin
            state_reg <= READ;
          end
        end

        REL: begin
          if (cnt_reg == 8'd0) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= REQ;
            sdma_reg  <= 1'b0;
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
          sdma_reg  <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_cpucr.sv
// tb_dma_cpucr -- directed bench for dma_cpucr: a 64 KiB memory model on the
// tri-state bus, a CPUCR arbiter model granting BD after a fixed delay, and
// hand-computed expected addresses, data, latencies and release counts.
module tb_dma_cpucr;

  logic clk = 1'b0;
  logic rps;

  always #5 clk = ~clk;

  dma_cpucr_if ctl ();

  // Pulled-up bus: an undriven Direccion reads FFFF and an undriven LE reads 1.
  tri1 [15:0] dir_w;
  tri1        le_w;
  wire [7:0]  datos_w;

  logic [7:0] mem [0:65535];

  // Memory drives the data bus whenever no write is in progress.
  assign datos_w = le_w ? mem[dir_w] : 8'hzz;

  dma_cpucr #(.BURST(4)) dut (
    .clk       (clk),
    .RPS       (rps),
    .ctl       (ctl),
    .Direccion (dir_w),
    .LE        (le_w),
    .Datos     (datos_w)
  );

  int checks = 0;
  int errors = 0;

  int done_cnt  = 0;
  int rel_cnt   = 0;
  int low_cnt   = 0;
  int busy_cnt  = 0;
  int bad_drive = 0;
  int drops     = 0;
  logic [15:0] wr_addr_q [$];

  // Arbiter model controls
  int grant_dly  = 2;
  int wait_cnt   = 0;
  int hold_cnt   = 0;
  bit drop_arm   = 1'b0;
  int drop_after = 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor and memory write port, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rps) begin
      if (ctl.done) done_cnt++;
      if (ctl.busy && ctl.SDMA) rel_cnt++;
      if (!ctl.SDMA) low_cnt++;
      if (ctl.busy) busy_cnt++;
      if ((!ctl.BD || ctl.SDMA) && (le_w == 1'b0 || dir_w != 16'hFFFF)) bad_drive++;
      if (le_w == 1'b0) begin
        mem[dir_w] = datos_w;
        wr_addr_q.push_back(dir_w);
      end
    end
  end

  // CPUCR arbiter: grant after grant_dly+1 cycles of SDMA low; optionally
  // withdraw the grant during a chosen WRITE and re-grant 3 cycles later.
  always @(posedge clk) begin
    #1;
    if (rps || ctl.SDMA) begin
      ctl.BD   = 1'b0;
      wait_cnt = 0;
      hold_cnt = 0;
    end else if (drop_arm && ctl.BD && le_w == 1'b0 && wr_addr_q.size() == drop_after) begin
      ctl.BD   = 1'b0;
      hold_cnt = 3;
      drop_arm = 1'b0;
      drops++;
    end else if (hold_cnt > 0) begin
      hold_cnt--;
      if (hold_cnt == 0) ctl.BD = 1'b1;
    end else if (!ctl.BD) begin
      wait_cnt++;
      if (wait_cnt > grant_dly) ctl.BD = 1'b1;
    end
  end

  task automatic set_src(input logic [15:0] s, input logic [15:0] d, input int n, input logic [7:0] seed);
    for (int i = 0; i < n; i++) begin
      mem[16'(s + i)] = 8'(seed + 8'h11 * i);
      mem[16'(d + i)] = 8'h00;
    end
  endtask

  task automatic run_copy(input string tag, input logic [15:0] s, input logic [15:0] d,
                          input logic [7:0] n, input logic [7:0] seed,
                          input int exp_lat, input int exp_rel, input bit extra_start);
    int lat;
    bit seen;
    logic busy_first;
    lat = 0;
    seen = 1'b0;
    busy_first = 1'b0;
    set_src(s, d, int'(n), seed);
    done_cnt = 0; rel_cnt = 0; low_cnt = 0; busy_cnt = 0;
    wr_addr_q.delete();
    @(posedge clk); #1;
    ctl.start = 1'b1; ctl.src_addr = s; ctl.dst_addr = d; ctl.len = n;
    @(posedge clk); #1;
    // Scramble inputs: the copy must use the values latched at start.
    ctl.start = 1'b0; ctl.src_addr = 16'hDEAD; ctl.dst_addr = 16'hBEEF; ctl.len = 8'hFF;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) busy_first = ctl.busy;
      if (extra_start && k == 3) begin
        ctl.start = 1'b1; ctl.src_addr = 16'h0000; ctl.dst_addr = 16'hF000; ctl.len = 8'd2;
      end
      if (extra_start && k == 4) ctl.start = 1'b0;
      if (ctl.done) begin
        seen = 1'b1;
        lat = k;
        break;
      end
    end
    repeat (6) @(negedge clk);
    check_eq({tag, ":done_seen"}, 32'(seen), 32'd1);
    check_eq({tag, ":busy_after_start"}, 32'(busy_first), 32'(n != 8'd0));
    if (exp_lat > 0) check_eq({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, ":done_pulses"}, 32'(done_cnt), 32'd1);
    check_eq({tag, ":releases"}, 32'(rel_cnt), 32'(exp_rel));
    check_eq({tag, ":writes"}, 32'(wr_addr_q.size()), 32'(n));
    check_eq({tag, ":sdma_idle"}, 32'(ctl.SDMA), 32'd1);
    for (int i = 0; i < int'(n); i++) begin
      if (i < wr_addr_q.size())
        check_eq($sformatf("%s:wr_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(16'(d + i)));
      check_eq($sformatf("%s:data%0d", tag, i), 32'(mem[16'(d + i)]), 32'(8'(seed + 8'h11 * i)));
    end
    $display("copy %s src=%h dst=%h len=%0d writes=%0d done=%0d releases=%0d latency=%0d",
             tag, s, d, n, wr_addr_q.size(), done_cnt, rel_cnt, lat);
  endtask

  initial begin
    bit found;
    rps = 1'b1;
    ctl.start = 1'b0; ctl.src_addr = 16'h0; ctl.dst_addr = 16'h0; ctl.len = 8'h0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    #22 rps = 1'b0;
    @(negedge clk);
    check_eq("reset:sdma", 32'(ctl.SDMA), 32'd1);
    check_eq("reset:busy", 32'(ctl.busy), 32'd0);
    check_eq("reset:done", 32'(ctl.done), 32'd0);
    check_eq("reset:le_hiz", 32'(le_w), 32'd1);
    check_eq("reset:addr_hiz", 32'(dir_w), 32'hFFFF);

    // Basic 3-byte copy, plus a start while busy that must be ignored.
    run_copy("basic", 16'h0100, 16'h0200, 8'd3, 8'hAA, 14, 1, 1'b1);

    // Zero length: done next cycle, bus never requested.
    run_copy("len0", 16'h0150, 16'h0250, 8'd0, 8'h00, 1, 0, 1'b0);
    check_eq("len0:sdma_low_cycles", 32'(low_cnt), 32'd0);
    check_eq("len0:busy_cycles", 32'(busy_cnt), 32'd0);

    // Burst release after bytes 4 and 8, final release after byte 10.
    run_copy("burst", 16'h0300, 16'h0400, 8'd10, 8'h01, 43, 3, 1'b0);

    // Source address wraps FFFF -> 0000.
    run_copy("wrap", 16'hFFFE, 16'h0010, 8'd4, 8'h11, 17, 1, 1'b0);

    // Grant withdrawn during the write of byte 2.
    drops = 0;
    drop_after = 1;
    drop_arm = 1'b1;
    run_copy("drop", 16'h0500, 16'h0600, 8'd5, 8'h30, 0, 1, 1'b0);
    check_eq("drop:grant_drops", 32'(drops), 32'd1);

    // Asynchronous reset in the middle of a WRITE.
    set_src(16'h0700, 16'h0800, 5, 8'h70);
    @(posedge clk); #1;
    ctl.start = 1'b1; ctl.src_addr = 16'h0700; ctl.dst_addr = 16'h0800; ctl.len = 8'd5;
    @(posedge clk); #1;
    ctl.start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (le_w == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("rst:write_reached", 32'(found), 32'd1);
    #1 rps = 1'b1;
    #1;
    check_eq("rst:sdma_async", 32'(ctl.SDMA), 32'd1);
    check_eq("rst:busy_async", 32'(ctl.busy), 32'd0);
    check_eq("rst:le_hiz", 32'(le_w), 32'd1);
    check_eq("rst:addr_hiz", 32'(dir_w), 32'hFFFF);
    repeat (2) @(posedge clk);
    @(negedge clk) rps = 1'b0;
    low_cnt = 0; busy_cnt = 0;
    repeat (6) @(negedge clk);
    check_eq("rst:stays_idle_sdma", 32'(low_cnt), 32'd0);
    check_eq("rst:stays_idle_busy", 32'(busy_cnt), 32'd0);
    run_copy("after_rst", 16'h0900, 16'h0A00, 8'd3, 8'h05, 14, 1, 1'b0);

    check_eq("bus_driven_without_grant", 32'(bad_drive), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_cpucr.md
DMA_CPUCR -- requirements
Module: dma_cpucr

Interface
REQ-001 Parameter: BURST, default 4, maximum bytes moved per bus tenure before SDMA is released for one cycle.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 RPS  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a block copy; sampled only in IDLE.
REQ-005 src_addr  input  16  first source byte address.
REQ-006 dst_addr  input  16  first destination byte address.
REQ-007 len  input  8  byte count; 0 means no transfer.
REQ-008 busy  output  1  high from the cycle after an accepted start until done.
REQ-009 done  output  1  one-cycle pulse on completion.
REQ-010 SDMA  output  1  bus request to CPUCR, active-low (1 = idle).
REQ-011 BD  input  1  bus grant from CPUCR, active-high.
REQ-012 Direccion  output  16  memory address; high-Z unless the block owns the bus.
REQ-013 LE  output  1  1 = memory read, 0 = memory write; high-Z unless the block owns the bus.
REQ-014 Datos  inout  8  data bus; driven only in WRITE, high-Z otherwise.

Function
REQ-015 States SHALL be IDLE, REQ, READ, WRITE, NEXT, REL, DONE.
REQ-016 IDLE: on start=1, latch src_addr, dst_addr, len into sp, dp, cnt; go to DONE if len=0, else to REQ; the latch happens even if inputs change next cycle.
REQ-017 REQ: SDMA=0; stay while BD=0; on BD=1 go to READ, clear burst counter.
REQ-018 READ: Direccion=sp, LE=1, Datos high-Z; the byte on Datos is captured into buf at the closing rising edge; next WRITE.
REQ-019 WRITE: Direccion=dp, LE=0, Datos=buf; next NEXT.
REQ-020 NEXT: sp+=1, dp+=1 (16-bit wrap FFFF->0000), cnt-=1, burst+=1; bus stays owned, Direccion/LE/Datos high-Z.
REQ-021 From NEXT: cnt reaching 0 -> REL then DONE; burst reaching BURST -> REL then REQ; otherwise -> READ.
REQ-022 REL: SDMA=1 for exactly one cycle, all bus outputs high-Z.
REQ-023 DONE: done=1 and SDMA=1 for one cycle; next IDLE; busy low in DONE.
REQ-024 One byte SHALL cost 3 cycles (READ, WRITE, NEXT) within a tenure; the first READ follows the BD=1 edge by one cycle.
REQ-025 BD falling to 0 in READ or WRITE: abort the byte (no pointer or count update), tri-state immediately in the next cycle, go to REQ and retry the same byte.
REQ-026 BD falling in NEXT: the NEXT updates complete, then go to REQ (or DONE if cnt=0).
REQ-027 start while not IDLE SHALL be ignored; no queuing.
REQ-028 Direccion, LE, Datos SHALL never be driven in IDLE, REQ, REL, DONE, or in any cycle where BD=0.

Reset
REQ-029 RPS=1 SHALL force IDLE immediately, independent of clk: SDMA=1, busy=0, done=0, Direccion/LE/Datos high-Z, sp=dp=0, cnt=0, buf=0.
REQ-030 RPS asserted mid-transfer SHALL abandon the copy; after release the block waits for a new start.

Verification
REQ-031 src=0x0100, dst=0x0200, len=3, BD granted 2 cycles after SDMA falls, memory 0x0100..0x0102 = AA,BB,CC -> 0x0200..0x0202 = AA,BB,CC, done pulses once, SDMA back to 1.
REQ-032 len=0 with start -> done pulses on the cycle after start, SDMA never leaves 1, bus never driven.
REQ-033 BURST=4, len=10 -> SDMA releases for one cycle after bytes 4 and 8; all 10 bytes copied in order.
REQ-034 src=0xFFFE, dst=0x0010, len=4 -> reads FFFE, FFFF, 0000, 0001; writes 0010..0013.
REQ-035 BD dropped during WRITE of byte 2 of 5, re-granted 3 cycles later -> byte 2 rewritten, destination correct, no byte skipped or duplicated in count, done once.
REQ-036 RPS pulsed while in WRITE -> outputs high-Z and SDMA=1 before next clk edge; a subsequent start runs a clean copy.
